// File: rtl/conv_enc_k7.sv
// -----------------------------------------------------------------------------
// conv_enc_k7 -- rate-1/2, constraint-length-7 convolutional encoder.
//
// Transmit-side partner of the 64-state Viterbi decoder. Each accepted data bit
// produces one 2-bit code symbol {G0 output, G1 output}. With TAIL_EN=1 every
// frame is followed by K-1 zero tail symbols, so the trellis ends in state 0.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_bit     in   1  data bit to encode
//   in_valid   in   1  in_bit / in_last valid
//   in_last    in   1  final data bit of a frame
//   in_ready   out  1  encoder accepts input this cycle (combinational)
//   tx_pair    out  2  code symbol {G0 parity, G1 parity}
//   out_valid  out  1  tx_pair / out_last valid
//   out_last   out  1  final symbol of the frame (tail included)
//   out_ready  in   1  downstream accepts the symbol
// -----------------------------------------------------------------------------
module conv_enc_k7 #(
    parameter int           K       = 7,
    parameter logic [K-1:0] G0      = 7'o171,
    parameter logic [K-1:0] G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] tx_pair,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int             CW        = $clog2(K - 1);
    localparam logic [CW-1:0]  TAIL_LAST = CW'(K - 2);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TAIL = 1'b1;

    // Even parity of a masked window: one generator output bit.
    function automatic logic parity(input logic [K-1:0] v);
        return ^v;
    endfunction

    // Window with the current bit in the MSB, then sr[0] (newest) down to
    // sr[K-2] (oldest) -- the generator MSB taps the current bit.
    function automatic logic [K-1:0] window(input logic u, input logic [K-2:0] sr);
        logic [K-1:0] w;
        w[K-1] = u;
        for (int i = 0; i < K - 1; i++) begin
            w[K-2-i] = sr[i];
        end
        return w;
    endfunction

    function automatic logic [1:0] encode(input logic u, input logic [K-2:0] sr);
        logic [K-1:0] w;
        w = window(u, sr);
        return {parity(w & G0), parity(w & G1)};
    endfunction

    logic [K-2:0]  sr_q, sr_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] tail_cnt_q, tail_cnt_d;
    logic [1:0]    tx_pair_q, tx_pair_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;

    logic advance_s;
    logic accept_s;
    logic tail_step_s;

    // Handshake qualifiers: the output register may be overwritten when empty
    // or when its current symbol is being taken this cycle.
    always_comb begin
        advance_s   = (out_valid_q == 1'b0) || out_ready;
        in_ready    = (state_q == ST_RUN) && advance_s;
        accept_s    = in_valid && in_ready;
        tail_step_s = (state_q == ST_TAIL) && advance_s;
    end

    // Next-state logic for shift register, phase, tail counter and output stage.
    always_comb begin
        sr_d        = sr_q;
        state_d     = state_q;
        tail_cnt_d  = tail_cnt_q;
        tx_pair_d   = tx_pair_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        if (accept_s) begin
            sr_d        = {sr_q[K-3:0], in_bit};
            tx_pair_d   = encode(in_bit, sr_q);
            out_valid_d = 1'b1;
            out_last_d  = in_last && (TAIL_EN == 1'b0);
            if (in_last && (TAIL_EN == 1'b1)) begin
                state_d    = ST_TAIL;
                tail_cnt_d = '0;
            end else begin
                state_d    = ST_RUN;
            end
        end else if (tail_step_s) begin
            // Flushing zeros; after K-1 of them sr is zero again.
            sr_d        = {sr_q[K-3:0], 1'b0};
            tx_pair_d   = encode(1'b0, sr_q);
            out_valid_d = 1'b1;
            out_last_d  = (tail_cnt_q == TAIL_LAST);
            if (tail_cnt_q == TAIL_LAST) begin
                state_d    = ST_RUN;
                tail_cnt_d = '0;
            end else begin
                tail_cnt_d = tail_cnt_q + CW'(1);
            end
        end else if (advance_s) begin
            // Symbol taken (or none held) and nothing new: go empty.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            // Stalled by downstream: hold everything.
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            state_q     <= ST_RUN;
            tail_cnt_q  <= '0;
            tx_pair_q   <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            state_q     <= state_d;
            tail_cnt_q  <= tail_cnt_d;
            tx_pair_q   <= tx_pair_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign tx_pair   = tx_pair_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_enc_k7.sv
module tb_conv_enc_k7;

    logic       clk;
    logic       rst_n;
    logic       in_bit, in_valid, in_last, out_ready;
    logic       in_ready, out_valid, out_last;
    logic [1:0] tx_pair;
    logic       in_bit0, in_valid0, in_last0, out_ready0;
    logic       in_ready0, out_valid0, out_last0;
    logic [1:0] tx_pair0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    bit bp_en = 1'b0;

    // entries are {last, g0, g1}
    logic [2:0] exp_q[$];
    logic [2:0] exp0_q[$];
    logic [5:0] msr;

    conv_enc_k7 #(.TAIL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .tx_pair(tx_pair),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    conv_enc_k7 #(.TAIL_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_bit(in_bit0), .in_valid(in_valid0),
        .in_last(in_last0), .in_ready(in_ready0), .tx_pair(tx_pair0),
        .out_valid(out_valid0), .out_last(out_last0), .out_ready(out_ready0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // downstream ready: random when backpressure is enabled
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
        else       out_ready = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // scoreboard monitor, TAIL_EN=1 instance
    initial begin
        logic       stall;
        logic [3:0] held;
        logic [2:0] e;
        stall = 1'b0;
        held  = 4'h0;
        forever begin
            @(negedge clk);
            if (stall) check("hold", {28'h0, out_valid, out_last, tx_pair}, {28'h0, held});
            stall = rst_n && out_valid && !out_ready;
            held  = {out_valid, out_last, tx_pair};
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL extra_sym got=%0h exp=none t=%0t", {out_last, tx_pair}, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sym", {29'h0, out_last, tx_pair}, {29'h0, e});
                end
            end
        end
    end

    // scoreboard monitor, TAIL_EN=0 instance
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid0 && out_ready0) begin
                if (exp0_q.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL extra_sym0 got=%0h exp=none t=%0t", {out_last0, tx_pair0}, $time);
                end else begin
                    e = exp0_q.pop_front();
                    check("sym0", {29'h0, out_last0, tx_pair0}, {29'h0, e});
                end
            end
        end
    end

    // reference: G0=171 taps u,s0,s1,s2,s5; G1=133 taps u,s1,s2,s4,s5
    task automatic model_bit(input logic u, input logic l);
        logic g0, g1;
        g0 = u ^ msr[0] ^ msr[1] ^ msr[2] ^ msr[5];
        g1 = u ^ msr[1] ^ msr[2] ^ msr[4] ^ msr[5];
        exp_q.push_back({l, g0, g1});
        msr = {msr[4:0], u};
    endtask

    task automatic model_tail();
        for (int i = 0; i < 6; i++) model_bit(1'b0, (i == 5));
    endtask

    task automatic push_impulse();
        exp_q.push_back(3'b011); exp_q.push_back(3'b010); exp_q.push_back(3'b011);
        exp_q.push_back(3'b011); exp_q.push_back(3'b000); exp_q.push_back(3'b001);
        exp_q.push_back(3'b111);
    endtask

    // present one bit and hold it until accepted; in_valid stays high on return
    task automatic send_bit(input logic b, input logic l);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        in_bit = b; in_last = l; in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
            if (!done && n > 500) begin
                check("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        acc_cyc = cyc;
    endtask

    task automatic send_bit0(input logic b, input logic l);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        in_bit0 = b; in_last0 = l; in_valid0 = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready0) done = 1'b1;
            @(posedge clk);
            #1;
            n = n + 1;
            if (!done && n > 500) begin
                check("accept_timeout0", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0) && n < 400) begin
            @(posedge clk);
            n = n + 1;
        end
        if (exp_q.size() != 0 || exp0_q.size() != 0)
            check("drain", exp_q.size() + exp0_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a_cyc;
        logic b;
        rst_n = 1'b0;
        in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_bit0 = 1'b0; in_valid0 = 1'b0; in_last0 = 1'b0; out_ready0 = 1'b1;
        msr = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_last", {31'h0, out_last}, 32'd0);
        check("rst_pair", {30'h0, tx_pair}, 32'd0);
        check("rst_ready", {31'h0, in_ready}, 32'd1);
        check("rst_valid0", {31'h0, out_valid0}, 32'd0);
        @(posedge clk);
        #1;

        // impulse: single-bit frame, tail blocks input
        push_impulse();
        send_bit(1'b1, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("tail_rdy", {31'h0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("post_tail_rdy", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        // all-zero 8-bit frame: 14 zero symbols, last on the 14th
        for (int i = 0; i < 13; i++) exp_q.push_back(3'b000);
        exp_q.push_back(3'b100);
        for (int i = 0; i < 8; i++) send_bit(1'b0, (i == 7));
        in_valid = 1'b0;
        drain();

        // no-tail instance: 1,0(last) then 1 with carried state
        exp0_q.push_back(3'b011);
        exp0_q.push_back(3'b110);
        exp0_q.push_back(3'b000);
        send_bit0(1'b1, 1'b0);
        send_bit0(1'b0, 1'b1);
        send_bit0(1'b1, 1'b0);
        in_valid0 = 1'b0;
        drain();

        // random 64-bit frame under ~50% backpressure
        msr = 6'd0;
        bp_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom_range(0, 1));
            model_bit(b, 1'b0);
            send_bit(b, (i == 63));
        end
        in_valid = 1'b0;
        model_tail();
        drain();
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // back-to-back frames: B held valid through A's tail
        msr = 6'd0;
        model_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        model_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        model_bit(1'b0, 1'b0); send_bit(1'b0, 1'b1);
        a_cyc = acc_cyc;
        model_tail();
        model_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        check("b2b_gap", acc_cyc - a_cyc, 32'd7);
        model_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0);
        model_bit(1'b1, 1'b0); send_bit(1'b1, 1'b1);
        in_valid = 1'b0;
        model_tail();
        drain();

        // reset pulse in the tail (tail_cnt==3)
        push_impulse();
        send_bit(1'b1, 1'b1);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        check("rst_pending", exp_q.size(), 32'd4);
        exp_q.delete();
        #2;
        check("rst_async_valid", {31'h0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_valid", {31'h0, out_valid}, 32'd0);
        check("rel_ready", {31'h0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        push_impulse();
        send_bit(1'b1, 1'b1);
        in_valid = 1'b0;
        drain();

        check("final_empty", exp_q.size() + exp0_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_enc_k7.md
Name: conv_enc_k7

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder; transmit-side counterpart of the 64-state Viterbi decoder.
- Encodes its output pairs exactly as the decoder's branch metric units expect.
- Accepts a framed serial bit stream over a valid/ready handshake and emits one 2-bit code symbol per accepted bit.
- Optionally appends K-1 zero tail bits so each frame terminates the trellis in state 0.

Parameters:
- K, 7, constraint length; shift register depth is K-1 = 6.
- G0, 7'o171, generator polynomial for tx_pair[1]; MSB taps the current input bit.
- G1, 7'o133, generator polynomial for tx_pair[0]; MSB taps the current input bit.
- TAIL_EN, 1, 1 = append K-1 zero tail symbols after each frame; 0 = no tail, state kept across frames.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  data bit to encode.
- in_valid  input  1  in_bit/in_last valid.
- in_last  input  1  marks final data bit of a frame.
- in_ready  output  1  encoder accepts input this cycle.
- tx_pair  output  2  code symbol: {G0 output, G1 output}.
- out_valid  output  1  tx_pair/out_last valid.
- out_last  output  1  final symbol of the frame, including tail.
- out_ready  input  1  downstream accepts symbol.

Behaviour:
- Reset (async, rst_n=0): sr=0, state=IDLE/DATA (merged, called RUN), tail_cnt=0, tx_pair=2'b00, out_valid=0, out_last=0.
- Window w = {u, sr[0], sr[1], ..., sr[5]}. u = current input bit. sr[k] = bit accepted k+1 steps earlier.
- tx_pair[1] = XOR of (w & G0); tx_pair[0] = XOR of (w & G1).
- Output stage: single register. A symbol "advances" when out_valid=0 or out_ready=1.
- in_ready = (state==RUN) and (out_valid==0 or out_ready==1). Purely combinational; must not depend on in_valid.
- Accept (in_valid & in_ready):
  - tx_pair, out_valid=1 and out_last=(in_last & !TAIL_EN) are registered next edge. Latency 1 cycle.
  - sr shifts: sr <= {sr[4:0], in_bit}.
- After accepting in_last with TAIL_EN=1: state -> TAIL, tail_cnt=0.
- TAIL:
  - in_ready=0.
  - Each advance emits the symbol for u=0 and shifts in 0; tail_cnt increments.
  - The 6th tail symbol (tail_cnt==5) has out_last=1.
  - Then state -> RUN; sr is all zero by construction.
- No new symbol and out_ready=0: tx_pair, out_valid and out_last hold unchanged (no drop, no duplicate).
- out_valid drops to 0 after a handshake if no new symbol is produced that cycle.
- Full throughput: 1 symbol/cycle with out_ready held high. No bubbles between the data and tail phases.
- TAIL_EN=0: in_last only drives out_last; sr is not cleared between frames.
- Single-bit frame (in_last on the first bit): valid, produces 1+6 symbols.
- Reset asserted mid-frame or mid-tail: all state cleared immediately, partial frame discarded, no out_last emitted.

Test Plan:
- Impulse: bits 1 with in_last=1, TAIL_EN=1, out_ready=1 -> tx_pair sequence 11,10,11,11,00,01,11; out_last only on the 7th symbol; in_ready=0 during the tail.
- All-zero frame of 8 bits -> 14 symbols, all 00, out_last on the 14th.
- Backpressure: random out_ready (about 50%) over a 64-bit random frame -> symbol stream identical to a golden model; no loss or duplication; tx_pair stable while out_valid=1 and out_ready=0.
- Back-to-back frames: second frame's in_valid held high during the first frame's tail -> second frame accepted on the cycle after the first frame's out_last symbol advances; its first symbol uses sr=0.
- TAIL_EN=0: bits 1,0 (last) then 1 -> symbols 11,10, then 00 for the third bit (state carried: w=1,0,1,0,0,0,0 gives G0=1^1=0, G1=1^1=0); out_last on the 2nd symbol.
- Reset pulse during the tail (tail_cnt=3) -> out_valid=0 and in_ready=1 after reset release; the next impulse frame reproduces 11,10,11,11,00,01,11.
